fetch_queue: RTL

//   Instruction fetch stage directly upstream of decode/execute. Owns the PC and

---
 rtl/fetch_queue.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: PC owner, single-outstanding imem requester, tagged FIFO.
// Optional same-cycle response bypass to the consumer when FETCHQ_BYPASS_EN is defined.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  output logic [15:0] inst_pc_nxt,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   tag_q, tag_d;
  logic          outstanding_q, outstanding_d;
  logic          drop_q, drop_d;
  logic          err_q, err_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   data_mem_q [DEPTH];
  logic [15:0]   pc_mem_q   [DEPTH];

  logic fifo_empty, issue, resp, keep, bypass, push, pop;

  always_comb begin
    fifo_empty = (count_q == '0);
    issue      = !rst && !halt && !redirect && !outstanding_q && (count_q < FULL);
    resp       = imem_valid && outstanding_q;
    keep       = resp && !drop_q && !redirect;
`ifdef FETCHQ_BYPASS_EN
    bypass     = keep && fifo_empty;
`else
    bypass     = 1'b0;
`endif
    // A bypassed response taken by the consumer never occupies a slot.
    push       = keep && !(bypass && inst_ready);
    pop        = !fifo_empty && inst_ready && !redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    tag_d         = tag_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    err_d         = err_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q + (AW + 1)'(push) - (AW + 1)'(pop);

    if (issue) begin
      outstanding_d = 1'b1;
      tag_d         = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 16'd2;
    end
    if (resp) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (redirect) begin
      fetch_pc_d = {redirect_pc[15:1], 1'b0};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_d     = outstanding_q && !imem_valid;
    end

    if ((imem_valid && !outstanding_q) || (redirect && redirect_pc[0])) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      tag_q         <= 16'h0000;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      err_q         <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      tag_q         <= tag_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      err_q         <= err_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q]   <= tag_q;
    end
  end

  // Head outputs read as zero whenever nothing is presented.
  always_comb begin
    inst    = 16'h0000;
    inst_pc = 16'h0000;
    if (!fifo_empty) begin
      inst    = data_mem_q[rd_ptr_q];
      inst_pc = pc_mem_q[rd_ptr_q];
    end else if (bypass) begin
      inst    = imem_data;
      inst_pc = tag_q;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = !fifo_empty || bypass;
  assign inst_pc_nxt = inst_valid ? inst_pc + 16'd2 : 16'h0000;
  assign err         = err_q;

endmodule
